// File: rtl/risc_pkg.sv
// risc_pkg: shared opcode, alu op and phase constants for the VeriRISC sequencer and alu
package risc_pkg;
  localparam int OPC_W = 4;
  localparam int ALU_OP_W = 3;
  localparam logic [OPC_W-1:0] OP_HLT = 4'd0, OP_SKZ = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3,
                               OP_AND = 4'd4, OP_OR = 4'd5, OP_XOR = 4'd6, OP_LDA = 4'd7,
                               OP_STO = 4'd8, OP_JMP = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                                  ALU_OR = 3'd3, ALU_XOR = 3'd4;
  localparam logic [2:0] PH_INST_ADDR = 3'd0, PH_INST_FETCH = 3'd1, PH_INST_LOAD = 3'd2,
                         PH_IDLE = 3'd3, PH_OP_ADDR = 3'd4, PH_OP_FETCH = 3'd5,
                         PH_ALU_OP = 3'd6, PH_STORE = 3'd7;
  typedef enum logic {ST_RUN, ST_HALTED} state_t;
  function automatic logic is_aluop(input logic [OPC_W-1:0] opc);
    return opc inside {[OP_ADD:OP_LDA]};
  endfunction
  // LDA reuses OR with operand a forced to zero, so the result is the memory operand
  function automatic logic [ALU_OP_W-1:0] alu_map(input logic [OPC_W-1:0] opc);
    return opc == OP_SUB ? ALU_SUB :
           opc == OP_AND ? ALU_AND :
           opc == OP_OR  ? ALU_OR  :
           opc == OP_XOR ? ALU_XOR :
           opc == OP_LDA ? ALU_OR  : ALU_ADD;
  endfunction
endpackage

// File: rtl/risc_sequencer_if.sv
// risc_sequencer_if: control bundle between the sequencer (master) and the datapath (slave)
interface risc_sequencer_if;
  import risc_pkg::*;
  logic                en;
  logic [OPC_W-1:0]    opcode;
  logic                zero;
  logic [ALU_OP_W-1:0] alu_op;
  logic                a_zero, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt;
  logic [2:0]          phase;
  modport master (input en, opcode, zero,
                  output alu_op, a_zero, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase);
  modport slave  (output en, opcode, zero,
                  input alu_op, a_zero, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, phase);
endinterface

// File: rtl/risc_phase_counter.sv
// risc_phase_counter: 3-bit wrapping phase counter with enable and hold
module risc_phase_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       hold_i,
  output logic [2:0] phase_o
);
  logic [2:0] phase_q, phase_d;
  // advance one phase per enabled clock unless held; 7 wraps to 0
  always_comb phase_d = (en_i && !hold_i) ? phase_q + 3'd1 : phase_q;
  // phase register
  always_ff @(posedge clk or posedge rst)
    if (rst) phase_q <= 3'd0;
    else     phase_q <= phase_d;
  assign phase_o = phase_q;
endmodule

// File: rtl/risc_sequencer.sv
// risc_sequencer: eight-phase VeriRISC instruction sequencer; RISC_SEQ_ILLEGAL_TRAP_EN adds an illegal-opcode trap
module risc_sequencer
  import risc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  risc_sequencer_if.master bus
`ifdef RISC_SEQ_ILLEGAL_TRAP_EN
  ,
  output logic             illegal_o
`endif
);
  state_t     state_q, state_d;
  logic [2:0] ph;
  logic       run, strobe, trap, go_halt;
  assign run     = state_q == ST_RUN;
  assign strobe  = run && bus.en;
  assign go_halt = strobe && ph == PH_OP_ADDR && (bus.opcode == OP_HLT || trap);
`ifdef RISC_SEQ_ILLEGAL_TRAP_EN
  logic illegal_q;
  assign trap = bus.opcode > OP_JMP;
  // sticky illegal flag, cleared only by reset
  always_ff @(posedge clk or posedge rst)
    if (rst)                  illegal_q <= 1'b0;
    else if (go_halt && trap) illegal_q <= 1'b1;
  assign illegal_o = illegal_q;
`else
  assign trap = 1'b0;
`endif
  // halting freezes the counter at the op-address phase
  risc_phase_counter u_phase (
    .clk    (clk),
    .rst    (rst),
    .en_i   (bus.en),
    .hold_i (!run || go_halt),
    .phase_o(ph)
  );
  // run/halted state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= ST_RUN;
    else     state_q <= state_d;
  // next state and decode; edge strobes gated by en, levels by run only
  always_comb begin
    state_d    = go_halt ? ST_HALTED : state_q;
    bus.sel    = run && ph <= PH_IDLE;
    bus.rd     = run && ((ph >= PH_INST_FETCH && ph <= PH_IDLE) || (is_aluop(bus.opcode) && ph >= PH_OP_FETCH));
    bus.ld_ir  = strobe && (ph == PH_INST_LOAD || ph == PH_IDLE);
    bus.inc_pc = strobe && ((ph == PH_OP_ADDR && !trap) || (ph == PH_ALU_OP && bus.opcode == OP_SKZ && bus.zero));
    bus.ld_ac  = strobe && ph == PH_STORE && is_aluop(bus.opcode);
    bus.ld_pc  = strobe && ph >= PH_ALU_OP && bus.opcode == OP_JMP;
    bus.data_e = run && ph >= PH_ALU_OP && bus.opcode == OP_STO;
    bus.wr     = strobe && ph == PH_STORE && bus.opcode == OP_STO;
    bus.halt   = !run;
    bus.alu_op = (run && !rst) ? alu_map(bus.opcode) : ALU_ADD;
    bus.a_zero = run && !rst && bus.opcode == OP_LDA;
    bus.phase  = ph;
  end
endmodule

// File: tb/tb_risc_sequencer.sv
// tb_risc_sequencer: randomized and directed scoreboard bench for risc_sequencer
module tb_risc_sequencer;
  typedef struct packed {
    logic [2:0] phase;
    logic halt, sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, a_zero;
    logic [2:0] alu_op;
    logic illegal;
  } obs_t;
`ifdef RISC_SEQ_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
  logic illegal;
`else
  localparam bit TRAP = 1'b0;
  wire illegal = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  int compared = 0, mismatched = 0, cyc = 0;
  obs_t q[$];
  bit done = 1'b0;
  int m_ph = 0;
  bit m_halt = 1'b0, m_ill = 1'b0;
  int alu_tbl[16] = '{0, 0, 0, 1, 2, 3, 4, 3, 0, 0, 0, 0, 0, 0, 0, 0};
  risc_sequencer_if bus();
  risc_sequencer dut (
    .clk(clk), .rst(rst), .bus(bus)
`ifdef RISC_SEQ_ILLEGAL_TRAP_EN
    , .illegal_o(illegal)
`endif
  );
  always #5 clk = ~clk;
  function automatic obs_t model(bit r, bit e, int o, bit z);
    obs_t x = '0;
    bit alu = o >= 2 && o <= 7;
    if (r) begin
      x.sel = 1'b1;
      return x;
    end
    if (m_halt) begin
      x.halt = 1'b1;
      x.phase = 3'd4;
      x.illegal = m_ill;
      return x;
    end
    x.phase  = 3'(m_ph);
    x.sel    = m_ph < 4;
    x.rd     = (m_ph >= 1 && m_ph <= 3) || (alu && m_ph >= 5);
    x.ld_ir  = e && (m_ph == 2 || m_ph == 3);
    x.inc_pc = e && ((m_ph == 4 && !(TRAP && o > 9)) || (m_ph == 6 && o == 1 && z));
    x.ld_ac  = e && m_ph == 7 && alu;
    x.ld_pc  = e && m_ph >= 6 && o == 9;
    x.data_e = m_ph >= 6 && o == 8;
    x.wr     = e && m_ph == 7 && o == 8;
    x.alu_op = 3'(alu_tbl[o]);
    x.a_zero = o == 7;
    return x;
  endfunction
  task automatic step(input bit r, input bit e, input int o, input bit z);
    @(negedge clk);
    rst = r;
    bus.en = e;
    bus.opcode = 4'(o);
    bus.zero = z;
    q.push_back(model(r, e, o, z));
    if (r) begin
      m_ph = 0;
      m_halt = 1'b0;
      m_ill = 1'b0;
    end else if (!m_halt && e) begin
      if (m_ph == 4 && (o == 0 || (TRAP && o > 9))) begin
        m_halt = 1'b1;
        m_ill = o > 9;
      end else m_ph = (m_ph + 1) % 8;
    end
  endtask
  task automatic instr(input int o, input bit z);
    step(1'b0, 1'b1, o, z);
    while (m_ph != 0 && !m_halt) step(1'b0, 1'b1, o, z);
  endtask
  initial begin : monitor
    obs_t act, e;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      while (q.size() > 0) begin
        e = q.pop_front();
        act = '{bus.phase, bus.halt, bus.sel, bus.rd, bus.wr, bus.ld_ir, bus.ld_ac, bus.ld_pc,
                bus.inc_pc, bus.data_e, bus.a_zero, bus.alu_op, illegal};
        compared++;
        if (act !== e) begin
          mismatched++;
          $display("FAIL cyc%0d outputs: got %b expected %b (phase,halt,sel,rd,wr,ld_ir,ld_ac,ld_pc,inc_pc,data_e,a_zero,alu_op,illegal)",
                   cyc, act, e);
        end
      end
    end
  end
  initial begin
    bus.en = 1'b0;
    bus.opcode = '0;
    bus.zero = 1'b0;
    step(1'b1, 1'b1, 2, 1'b0);
    step(1'b1, 1'b1, 7, 1'b1);
    step(1'b0, 1'b1, 2, 1'b0);
    while (m_ph != 0) step(1'b0, 1'b1, 2, 1'b0);
    instr(1, 1'b1);
    instr(1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1, i[0]);
    instr(8, 1'b0);
    instr(9, 1'b0);
    instr(7, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 2, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2, 1'b0);
    step(1'b0, 1'b1, 2, 1'b0);
    step(1'b0, 1'b1, 2, 1'b0);
    while (m_ph != 0) step(1'b0, 1'b1, 2, 1'b0);
    instr(0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, i[0], $urandom_range(0, 15), i[1]);
    step(1'b1, 1'b1, 0, 1'b0);
    step(1'b0, 1'b1, 2, 1'b0);
    while (m_ph != 0) step(1'b0, 1'b1, 2, 1'b0);
    instr(12, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 12, 1'b0);
    step(1'b1, 1'b1, 2, 1'b0);
    for (int n = 0; n < 60; n++) begin
      int o = $urandom_range(0, 15);
      if (o == 0 && $urandom_range(0, 3) != 0) o = 2;
      for (int k = 0; k < 64 && !m_halt; k++) begin
        step(1'b0, $urandom_range(0, 3) != 0, o, $urandom_range(0, 1));
        if (m_ph == 0) break;
      end
      if (m_halt) begin
        for (int k = 0; k < 4; k++) step(1'b0, $urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1));
        step(1'b1, 1'b1, $urandom_range(0, 15), 1'b0);
      end
    end
    repeat (3) @(negedge clk);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
